// File: rtl/imem_pkg.sv
// Shared types, defaults and elaboration helpers for the synchronous instruction memory.
package imem_pkg;

  // Sequencer states: normal fetch/load operation or NOP sweep of the whole array.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } imem_state_t;

  // Source of the presented instruction word.
  typedef enum logic [1:0] {
    SEL_NOP = 2'd0,  // reset value or out-of-range fetch
    SEL_RAM = 2'd1,  // synchronous array read
    SEL_BYP = 2'd2   // write-first forward of a same-cycle load
  } imem_sel_t;

  // Default fill/fault instruction.
  localparam logic [15:0] NOP_DEFAULT = 16'h0000;

  // Ceiling log2, evaluated at elaboration time; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/imem_ram_dp.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// Read-during-write to the same word returns the old contents; the top level
// forwards load data itself when write-first behaviour is needed.
module imem_ram_dp
  import imem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256,
  parameter int IDX_W     = (clog2(DEPTH) < 32'sd1) ? 32'sd1 : clog2(DEPTH),
  parameter     INIT_FILE = "program.hex"
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_r;

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: word captured on enable and held until the next enabled read.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory: valid/ready fetch port with one-cycle latency,
// program-load write port with write-first forwarding, flush, range-fault
// reporting and a NOP clear sequencer that sweeps every word once.
module imem_sync
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 256,
  parameter                    INIT_FILE = "program.hex",
  parameter logic [DATA_W-1:0] NOP       = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_fault,
  input  logic              flush,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear_req,
  output logic              clear_busy
);

  // Word index width; a single-word memory still gets a 1-bit index.
  localparam int IDX_W = (clog2(DEPTH) < 32'sd1) ? 32'sd1 : clog2(DEPTH);
  localparam int AW1   = ADDR_W + 32'sd1;
  // DEPTH widened by one bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]  DEPTH_EXT = AW1'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 32'sd1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(32'd1);

  // Sequencer state
  imem_state_t       state_r;
  logic [IDX_W-1:0]  cnt_r;
  logic              clear_busy_r;

  // Response registers
  logic              instr_valid_r;
  logic [ADDR_W-1:0] instr_addr_r;
  logic              instr_fault_r;
  imem_sel_t         sel_r;
  logic [DATA_W-1:0] byp_data_r;

  // Combinational control
  logic              fetch_in_range_s;
  logic              load_in_range_s;
  logic              fetch_ready_s;
  logic              accept_s;
  logic              load_hit_s;
  logic              ram_re_s;
  logic              ram_we_s;
  logic [IDX_W-1:0]  ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic [DATA_W-1:0] instr_s;

  // Range checks, fetch handshake and same-address load detection.
  always_comb begin
    fetch_in_range_s = ({1'b0, fetch_addr} < DEPTH_EXT);
    load_in_range_s  = ({1'b0, load_addr} < DEPTH_EXT);
    if ((state_r == RUN) && !flush && (!instr_valid_r || instr_ready)) begin
      fetch_ready_s = 1'b1;
    end else begin
      fetch_ready_s = 1'b0;
    end
    accept_s   = fetch_req & fetch_ready_s;
    // Out-of-range fetches never touch the array.
    ram_re_s   = accept_s & fetch_in_range_s;
    // Forward load data when the load and the accepted fetch name the same valid word.
    load_hit_s = load_we & load_in_range_s & fetch_in_range_s & (load_addr == fetch_addr);
  end

  // Write-port mux: the sweep owns the port in CLEAR, the loader owns it in RUN.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = IDX_ZERO;
    ram_wdata_s = NOP;
    case (state_r)
      CLEAR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = cnt_r;
        ram_wdata_s = NOP;
      end
      RUN: begin
        // Out-of-range loads are silently dropped.
        ram_we_s    = load_we & load_in_range_s;
        ram_waddr_s = load_addr[IDX_W-1:0];
        ram_wdata_s = load_data;
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_waddr_s = IDX_ZERO;
        ram_wdata_s = NOP;
      end
    endcase
  end

  // Clear sequencer: one NOP write per cycle, exactly DEPTH cycles, no restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RUN;
      cnt_r        <= IDX_ZERO;
      clear_busy_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (clear_req) begin
            state_r      <= CLEAR;
            cnt_r        <= IDX_ZERO;
            clear_busy_r <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_r == LAST_IDX) begin
            state_r      <= RUN;
            cnt_r        <= IDX_ZERO;
            clear_busy_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + IDX_ONE;
          end
        end
        default: begin
          state_r      <= RUN;
          cnt_r        <= IDX_ZERO;
          clear_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Response tracking: valid, address, fault flag and data source of the presented word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid_r <= 1'b0;
      instr_addr_r  <= {ADDR_W{1'b0}};
      instr_fault_r <= 1'b0;
      sel_r         <= SEL_NOP;
      byp_data_r    <= NOP;
    end else begin
      // Flush and the start of a sweep both drop whatever is presented.
      if (flush) begin
        instr_valid_r <= 1'b0;
      end else if ((state_r == RUN) && clear_req) begin
        instr_valid_r <= 1'b0;
      end else if (accept_s) begin
        instr_valid_r <= 1'b1;
      end else if (instr_ready) begin
        instr_valid_r <= 1'b0;
      end else begin
        instr_valid_r <= instr_valid_r;
      end
      // Accept only happens when nothing is held, so a stalled response stays stable.
      if (accept_s) begin
        instr_addr_r  <= fetch_addr;
        instr_fault_r <= ~fetch_in_range_s;
        if (!fetch_in_range_s) begin
          sel_r <= SEL_NOP;
        end else if (load_hit_s) begin
          sel_r      <= SEL_BYP;
          byp_data_r <= load_data;
        end else begin
          sel_r <= SEL_RAM;
        end
      end
    end
  end

  // Instruction word selection from the registered source.
  always_comb begin
    case (sel_r)
      SEL_RAM: instr_s = ram_rdata_s;
      SEL_BYP: instr_s = byp_data_r;
      SEL_NOP: instr_s = NOP;
      default: instr_s = NOP;
    endcase
  end

  imem_ram_dp #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (ram_rdata_s)
  );

  assign fetch_ready = fetch_ready_s;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_s;
  assign instr_addr  = instr_addr_r;
  assign instr_fault = instr_fault_r;
  assign clear_busy  = clear_busy_r;

endmodule
